// File: rtl/simple_fifo_ctrl_if.sv
// Producer/consumer handshake of the show-ahead FIFO controller.
// master = the client side, slave = the FIFO controller itself.
interface simple_fifo_ctrl_if #(
  parameter int width  = 8,
  parameter int widthu = 4
);
  logic              wrreq;
  logic [width-1:0]  data;
  logic              rdreq;
  logic [width-1:0]  q;
  logic              empty;
  logic              full;
  logic              almost_full;
  logic [widthu:0]   usedw;
  logic              overflow;
  logic              underflow;

  modport master (
    output wrreq, data, rdreq,
    input  q, empty, full, almost_full, usedw, overflow, underflow
  );

  modport slave (
    input  wrreq, data, rdreq,
    output q, empty, full, almost_full, usedw, overflow, underflow
  );
endinterface

// File: rtl/simple_fifo_ctrl.sv
// Show-ahead synchronous FIFO controller driving an external dual-port RAM
// with a registered read address; owns pointers, occupancy and status flags.
module simple_fifo_ctrl #(
  parameter int width      = 8,
  parameter int widthu     = 4,
  parameter int almost_lvl = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclr,
  simple_fifo_ctrl_if.slave fifo,
  output logic [widthu-1:0] ram_wraddress,
  output logic              ram_wren,
  output logic [width-1:0]  ram_data,
  output logic [widthu-1:0] ram_rdaddress,
  input  logic [width-1:0]  ram_q
);
  localparam logic [widthu:0] depth     = (widthu+1)'(2**widthu);
  localparam logic [widthu:0] almost_th = (widthu+1)'(almost_lvl);

  logic [widthu-1:0] wr_ptr_reg;
  logic [widthu-1:0] rd_ptr_reg;
  logic [widthu:0]   usedw_reg;
  logic [widthu:0]   usedw_next;
  logic              empty_reg;
  logic              full_reg;
  logic              almost_full_reg;
  logic              overflow_reg;
  logic              underflow_reg;
  logic              do_wr;
  logic              do_rd;

  always_comb begin
    do_wr      = fifo.wrreq & ~full_reg;
    do_rd      = fifo.rdreq & ~empty_reg;
    usedw_next = usedw_reg + (widthu+1)'(do_wr) - (widthu+1)'(do_rd);
  end

  // Read address looks one entry ahead on a pop so the RAM's registered
  // read lands on the new head right after the edge.
  assign ram_rdaddress = rd_ptr_reg + widthu'(do_rd);
  assign ram_wraddress = wr_ptr_reg;
  assign ram_data      = fifo.data;
  assign ram_wren      = do_wr & rst_n & ~sclr;

  always_ff @(posedge clk) begin
    if (!rst_n || sclr) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      usedw_reg       <= '0;
      empty_reg       <= 1'b1;
      full_reg        <= 1'b0;
      almost_full_reg <= 1'b0;
      overflow_reg    <= 1'b0;
      underflow_reg   <= 1'b0;
    end else begin
      if (do_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      usedw_reg       <= usedw_next;
      empty_reg       <= (usedw_next == '0);
      full_reg        <= (usedw_next == depth);
      almost_full_reg <= (usedw_next >= almost_th);
      if (fifo.wrreq && full_reg)  overflow_reg  <= 1'b1;
      if (fifo.rdreq && empty_reg) underflow_reg <= 1'b1;
    end
  end

  assign fifo.q           = empty_reg ? '0 : ram_q;
  assign fifo.empty       = empty_reg;
  assign fifo.full        = full_reg;
  assign fifo.almost_full = almost_full_reg;
  assign fifo.usedw       = usedw_reg;
  assign fifo.overflow    = overflow_reg;
  assign fifo.underflow   = underflow_reg;
endmodule

// File: tb/tb_simple_fifo_ctrl.sv
// Directed bench for simple_fifo_ctrl with a behavioural simple_ram
// (registered read address, write data visible on same-edge read).
module tb_simple_fifo_ctrl;
  localparam int W  = 8;
  localparam int WU = 2;
  localparam int AL = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclr = 1'b0;
  always #5 clk = ~clk;

  simple_fifo_ctrl_if #(.width(W), .widthu(WU)) f ();

  logic [WU-1:0] ram_wraddress;
  logic [WU-1:0] ram_rdaddress;
  logic          ram_wren;
  logic [W-1:0]  ram_data;
  logic [W-1:0]  ram_q;
  logic [W-1:0]  mem [0:(1<<WU)-1];
  logic [WU-1:0] rdaddr_q;

  always @(posedge clk) begin
    if (ram_wren) mem[ram_wraddress] <= ram_data;
    rdaddr_q <= ram_rdaddress;
  end
  assign ram_q = mem[rdaddr_q];

  simple_fifo_ctrl #(.width(W), .widthu(WU), .almost_lvl(AL)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sclr         (sclr),
    .fifo         (f),
    .ram_wraddress(ram_wraddress),
    .ram_wren     (ram_wren),
    .ram_data     (ram_data),
    .ram_rdaddress(ram_rdaddress),
    .ram_q        (ram_q)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0] st;
  logic [7:0] exp_st;

  // status vector: {usedw[2:0], empty, full, almost_full, overflow, underflow}
  always_comb st = {f.usedw, f.empty, f.full, f.almost_full, f.overflow, f.underflow};

  task automatic drive(input logic wr, input logic [W-1:0] d, input logic rd);
    f.wrreq = wr;
    f.data  = d;
    f.rdreq = rd;
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    $display("%s: wr=%0b rd=%0b data=%02h sclr=%0b -> q=%02h usedw=%0d e=%0b f=%0b af=%0b ov=%0b un=%0b",
             tag, f.wrreq, f.rdreq, f.data, sclr, f.q, f.usedw, f.empty, f.full,
             f.almost_full, f.overflow, f.underflow);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 8'h99, 1'b1);
    #1;
    total++;
    if (ram_wren !== 1'b0) begin
      bad++;
      $display("FAIL reset_wren got=%0b want=0", ram_wren);
    end
    tick("reset");
    total++;
    if (st !== 8'b000_1_0_0_0_0 || f.q !== 8'h00) begin
      bad++;
      $display("FAIL reset_state got st=%08b q=%02h want st=00010000 q=00", st, f.q);
    end
    drive(1'b0, 8'h00, 1'b0);
    rst_n = 1'b1;
    tick("idle");
    total++;
    if (st !== 8'b000_1_0_0_0_0 || f.q !== 8'h00) begin
      bad++;
      $display("FAIL idle_state got st=%08b q=%02h want st=00010000 q=00", st, f.q);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, W'(17 * i), 1'b0);
      #1;
      total++;
      if ({ram_wren, ram_wraddress, ram_data} !== {1'b1, WU'(i - 1), W'(17 * i)}) begin
        bad++;
        $display("FAIL push_ram%0d got wren=%0b addr=%0d data=%02h want wren=1 addr=%0d data=%02h",
                 i, ram_wren, ram_wraddress, ram_data, i - 1, W'(17 * i));
      end
      tick("push");
      exp_st = {3'(i), 1'b0, (i == 4), (i >= AL), 2'b00};
      total++;
      if (st !== exp_st || f.q !== 8'h11) begin
        bad++;
        $display("FAIL push%0d got st=%08b q=%02h want st=%08b q=11", i, st, f.q, exp_st);
      end
    end
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 8'h00, 1'b1);
      tick("pop");
      exp_st = {3'(4 - i), (i == 4), 1'b0, ((4 - i) >= AL), 2'b00};
      total++;
      if (st !== exp_st || f.q !== ((i < 4) ? W'(17 * (i + 1)) : 8'h00)) begin
        bad++;
        $display("FAIL pop%0d got st=%08b q=%02h want st=%08b q=%02h", i, st, f.q, exp_st,
                 (i < 4) ? W'(17 * (i + 1)) : 8'h00);
      end
    end
    drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, W'(17 * i), 1'b0);
      tick("refill");
    end
    drive(1'b1, 8'h55, 1'b0);
    #1;
    total++;
    if (ram_wren !== 1'b0) begin
      bad++;
      $display("FAIL full_wren got=%0b want=0", ram_wren);
    end
    tick("push_full");
    total++;
    if (st !== 8'b100_0_1_1_1_0 || f.q !== 8'h11) begin
      bad++;
      $display("FAIL overflow got st=%08b q=%02h want st=10001110 q=11", st, f.q);
    end
    drive(1'b0, 8'h00, 1'b0);
    tick("hold");
    total++;
    if (f.overflow !== 1'b1 || f.usedw !== 3'd4) begin
      bad++;
      $display("FAIL overflow_sticky got ov=%0b usedw=%0d want ov=1 usedw=4", f.overflow, f.usedw);
    end
  endtask

  task automatic test_full_rw();
    drive(1'b1, 8'h66, 1'b1);
    tick("full_rw");
    total++;
    if (st !== 8'b011_0_0_1_1_0 || f.q !== 8'h22) begin
      bad++;
      $display("FAIL full_rw got st=%08b q=%02h want st=01100110 q=22", st, f.q);
    end
    for (int i = 1; i <= 3; i++) begin
      drive(1'b0, 8'h00, 1'b1);
      tick("pop");
      total++;
      if (f.q !== ((i < 3) ? W'(17 * (i + 2)) : 8'h00) || f.usedw !== 3'(3 - i)) begin
        bad++;
        $display("FAIL full_rw_drain%0d got q=%02h usedw=%0d want q=%02h usedw=%0d", i, f.q,
                 f.usedw, (i < 3) ? W'(17 * (i + 2)) : 8'h00, 3 - i);
      end
    end
    total++;
    if (st !== 8'b000_1_0_0_1_0) begin
      bad++;
      $display("FAIL dropped_write got st=%08b want st=00010010", st);
    end
    drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_wrap();
    sclr = 1'b1;
    tick("sclr");
    sclr = 1'b0;
    total++;
    if (st !== 8'b000_1_0_0_0_0) begin
      bad++;
      $display("FAIL sclr_ov got st=%08b want st=00010000", st);
    end
    drive(1'b1, 8'hA0, 1'b0);
    tick("push");
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, W'(8'hA1 + i), 1'b1);
      tick("pushpop");
      total++;
      if (st !== 8'b001_0_0_0_0_0 || f.q !== W'(8'hA1 + i)) begin
        bad++;
        $display("FAIL wrap%0d got st=%08b q=%02h want st=00100000 q=%02h", i, st, f.q,
                 W'(8'hA1 + i));
      end
    end
    drive(1'b0, 8'h00, 1'b1);
    tick("pop");
    total++;
    if (st !== 8'b000_1_0_0_0_0 || f.q !== 8'h00) begin
      bad++;
      $display("FAIL wrap_drain got st=%08b q=%02h want st=00010000 q=00", st, f.q);
    end
  endtask

  task automatic test_empty_rw();
    drive(1'b0, 8'h00, 1'b1);
    tick("pop_empty");
    total++;
    if (st !== 8'b000_1_0_0_0_1 || f.q !== 8'h00) begin
      bad++;
      $display("FAIL underflow got st=%08b q=%02h want st=00010001 q=00", st, f.q);
    end
    drive(1'b1, 8'hA5, 1'b1);
    tick("empty_rw");
    total++;
    if (st !== 8'b001_0_0_0_0_1 || f.q !== 8'hA5) begin
      bad++;
      $display("FAIL empty_rw got st=%08b q=%02h want st=00100001 q=a5", st, f.q);
    end
    drive(1'b1, 8'h5A, 1'b0);
    sclr = 1'b1;
    #1;
    total++;
    if (ram_wren !== 1'b0) begin
      bad++;
      $display("FAIL sclr_wren got=%0b want=0", ram_wren);
    end
    tick("sclr");
    sclr = 1'b0;
    total++;
    if (st !== 8'b000_1_0_0_0_0 || f.q !== 8'h00) begin
      bad++;
      $display("FAIL sclr_clear got st=%08b q=%02h want st=00010000 q=00", st, f.q);
    end
    drive(1'b1, 8'h77, 1'b0);
    tick("push");
    total++;
    if (st !== 8'b001_0_0_0_0_0 || f.q !== 8'h77) begin
      bad++;
      $display("FAIL post_sclr_push got st=%08b q=%02h want st=00100000 q=77", st, f.q);
    end
    drive(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    drive(1'b0, 8'h00, 1'b0);
    test_reset();
    test_fill_drain();
    test_overflow();
    test_full_rw();
    test_wrap();
    test_empty_rw();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
